// File: rtl/data_sram_responder.sv
// Memory-side responder for the core's data-SRAM port: RAM window plus LED/TIMER/WRCNT MMIO.
// Optional free-running timer register is built only when DSRAM_TIMER_EN is defined.
module data_sram_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h1C00_0000,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  output logic [31:0] wr_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Word offsets inside the MMIO page
  localparam logic [9:0] OffLed   = 10'd0;
  localparam logic [9:0] OffTimer = 10'd1;
  localparam logic [9:0] OffWrcnt = 10'd2;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  logic          ram_hit, mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [9:0]    mmio_off;
  logic          ram_we;
  logic          wr_accept;

  logic unused_addr;
  assign unused_addr = ^sram_addr[1:0];

  // RAM_BASE is DEPTH*4 aligned, so the window test reduces to an upper-bit match
  assign ram_hit  = (sram_addr[31:AW+2] == RAM_BASE[31:AW+2]);
  assign ram_idx  = sram_addr[AW+1:2];
  assign mmio_hit = (sram_addr[31:12] == MMIO_BASE[31:12]);
  assign mmio_off = sram_addr[11:2];

`ifdef DSRAM_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic        timer_wr;
`endif

  always_comb begin
    rdata_d   = 32'h0;
    led_d     = led_q;
    ram_we    = 1'b0;
    wr_accept = 1'b0;
`ifdef DSRAM_TIMER_EN
    timer_wr  = 1'b0;
`endif
    if (ram_hit) begin
      rdata_d   = mem_q[ram_idx];
      ram_we    = sram_we & resetn;
      wr_accept = sram_we;
    end else if (mmio_hit) begin
      case (mmio_off)
        OffLed: begin
          rdata_d   = {16'h0, led_q};
          wr_accept = sram_we;
          if (sram_we) led_d = sram_wdata[15:0];
        end
`ifdef DSRAM_TIMER_EN
        OffTimer: begin
          rdata_d   = timer_q;
          wr_accept = sram_we;
          timer_wr  = sram_we;
        end
`endif
        OffWrcnt: begin
          rdata_d   = wr_cnt_q;
          wr_accept = sram_we;
        end
        default: ;
      endcase
    end
    wr_cnt_d = wr_cnt_q + 32'(wr_accept);
`ifdef DSRAM_TIMER_EN
    timer_d  = timer_wr ? sram_wdata : timer_q + 32'd1;
`endif
  end

  // RAM contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_idx] <= sram_wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q  <= 32'h0;
      led_q    <= 16'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rdata_q  <= rdata_d;
      led_q    <= led_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

`ifdef DSRAM_TIMER_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timer_q <= 32'h0;
    else         timer_q <= timer_d;
  end
`endif

  assign sram_rdata = rdata_q;
  assign led        = led_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed cases, mid-cycle reset and random traffic
// compared against a behavioural address-map model.
module tb_data_sram_responder;

  localparam int unsigned DEPTH     = 1024;
  localparam logic [31:0] RAM_BASE  = 32'h1C00_0000;
  localparam logic [31:0] MMIO_BASE = 32'hBFAF_0000;
  localparam logic [31:0] A_LED     = MMIO_BASE + 32'h0;
  localparam logic [31:0] A_TIMER   = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_WRCNT   = MMIO_BASE + 32'h8;
`ifdef DSRAM_TIMER_EN
  localparam bit TimerEn = 1'b1;
`else
  localparam bit TimerEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [15:0] led;
  logic [31:0] wr_cnt;

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [31:0] m_mem [int unsigned];
  logic [15:0] m_led;
  logic [31:0] m_timer;
  logic [31:0] m_wrcnt;

  always #5 clk = ~clk;

  data_sram_responder #(
    .DEPTH    (DEPTH),
    .RAM_BASE (RAM_BASE),
    .MMIO_BASE(MMIO_BASE)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .led       (led),
    .wr_cnt    (wr_cnt)
  );

  function automatic bit is_ram(input logic [31:0] a);
    logic [32:0] lo, hi, x;
    lo = {1'b0, RAM_BASE};
    hi = lo + 33'(DEPTH * 4);
    x  = {1'b0, a};
    return (x >= lo) && (x < hi);
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >> 12) == (MMIO_BASE >> 12);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_led   = 16'h0;
    m_timer = 32'h0;
    m_wrcnt = 32'h0;
  endtask

  // One clock of traffic: expected read from pre-edge state, then apply write rules
  task automatic step(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input string tag);
    logic [31:0] exp_rd;
    logic [31:0] off;
    logic [31:0] nxt_timer;
    bit          known;
    int unsigned idx;
    known  = 1'b1;
    exp_rd = 32'h0;
    off    = addr & 32'h0000_0FFC;
    idx    = (addr - RAM_BASE) >> 2;
    if (is_ram(addr)) begin
      if (m_mem.exists(idx)) exp_rd = m_mem[idx];
      else known = 1'b0;
    end else if (is_mmio(addr)) begin
      if (off == 32'h0) exp_rd = {16'h0, m_led};
      else if (off == 32'h4) exp_rd = TimerEn ? m_timer : 32'h0;
      else if (off == 32'h8) exp_rd = m_wrcnt;
    end
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wd;
    @(posedge clk);
    nxt_timer = m_timer + 32'd1;
    if (we) begin
      if (is_ram(addr)) begin
        m_mem[idx] = wd;
        m_wrcnt++;
      end else if (is_mmio(addr)) begin
        if (off == 32'h0) begin
          m_led = wd[15:0];
          m_wrcnt++;
        end else if (off == 32'h4 && TimerEn) begin
          nxt_timer = wd;
          m_wrcnt++;
        end else if (off == 32'h8) begin
          m_wrcnt++;
        end
      end
    end
    m_timer = nxt_timer;
    #1;
    if (known) check({tag, ".rdata"}, sram_rdata, exp_rd);
    check({tag, ".led"}, {16'h0, led}, {16'h0, m_led});
    check({tag, ".wr_cnt"}, wr_cnt, m_wrcnt);
  endtask

  initial begin
    logic [31:0] a;
    resetn     = 1'b0;
    sram_we    = 1'b1;
    sram_addr  = A_LED;
    sram_wdata = 32'hFFFF_FFFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por.rdata", sram_rdata, 32'h0);
    check("por.led", {16'h0, led}, 32'h0);
    check("por.wr_cnt", wr_cnt, 32'h0);
    @(negedge clk);
    sram_we = 1'b0;
    resetn  = 1'b1;

    step(1'b0, A_TIMER, 32'h0, "timer_first");
    step(1'b1, 32'h1C00_0010, 32'hDEAD_BEEF, "ram_wr");
    step(1'b0, 32'h1C00_0010, 32'h0, "ram_rd");
    step(1'b0, 32'h1C00_0013, 32'h0, "ram_rd_lowbits");
    step(1'b1, 32'h1C00_0014, 32'h0000_0011, "coll_pre");
    step(1'b1, 32'h1C00_0014, 32'h0000_0022, "coll");
    step(1'b0, 32'h1C00_0014, 32'h0, "coll_after");
    step(1'b1, A_LED, 32'h1234_ABCD, "led_wr");
    step(1'b0, A_LED, 32'h0, "led_rd");
    step(1'b1, A_WRCNT, 32'h0000_0005, "wrcnt_wr");
    step(1'b0, A_WRCNT, 32'h0, "wrcnt_rd");
    step(1'b1, 32'h0000_0000, 32'h9999_9999, "miss_wr");
    step(1'b0, RAM_BASE + DEPTH * 4, 32'h0, "miss_rd_top");
    step(1'b1, RAM_BASE + DEPTH * 4 - 4, 32'hCAFE_F00D, "ram_last_wr");
    step(1'b0, RAM_BASE + DEPTH * 4 - 4, 32'h0, "ram_last_rd");
    step(1'b0, RAM_BASE - 4, 32'h0, "miss_rd_below");
    step(1'b1, MMIO_BASE + 32'hC, 32'h7777_7777, "unmapped_wr");
    step(1'b0, MMIO_BASE + 32'hC, 32'h0, "unmapped_rd");
    step(1'b1, A_TIMER, 32'hFFFF_FFFE, "timer_wr");
    step(1'b0, A_TIMER, 32'h0, "timer_rd0");
    step(1'b0, A_TIMER, 32'h0, "timer_rd1");
    step(1'b0, A_TIMER, 32'h0, "timer_rd2");

    // Asynchronous reset in the middle of a cycle, with writes attempted during it
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    check("mid_rst.rdata", sram_rdata, 32'h0);
    check("mid_rst.led", {16'h0, led}, 32'h0);
    check("mid_rst.wr_cnt", wr_cnt, 32'h0);
    sram_we    = 1'b1;
    sram_addr  = 32'h1C00_0014;
    sram_wdata = 32'h0000_0BAD;
    @(posedge clk);
    sram_addr  = A_LED;
    @(posedge clk);
    #1;
    check("in_rst.led", {16'h0, led}, 32'h0);
    check("in_rst.wr_cnt", wr_cnt, 32'h0);
    check("in_rst.rdata", sram_rdata, 32'h0);
    @(negedge clk);
    sram_we = 1'b0;
    resetn  = 1'b1;
    step(1'b0, 32'h1C00_0014, 32'h0, "ram_kept");
    step(1'b0, A_TIMER, 32'h0, "timer_after_rst");

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: a = RAM_BASE + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
        3:       a = RAM_BASE + 32'((DEPTH - 1 - $urandom_range(0, 3)) << 2);
        4, 5:    a = MMIO_BASE + 32'($urandom_range(0, 5) << 2);
        6:       a = RAM_BASE + DEPTH * 4 + 32'($urandom_range(0, 3) << 2);
        default: a = $urandom;
      endcase
      step(1'($urandom_range(0, 1)), a, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
